chunked_adder: RTL and testbench



---
 rtl/chunked_adder.sv | 133 +++++++++++++
 tb/tb_chunked_adder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock through a small
// ripple slice, holding the inter-chunk carry in a register. Valid/ready on both
// sides; ready_o and valid_o are pure decodes of the registered state.
module chunked_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CntW-1:0]  LastCnt   = CntW'(N - 1);
    localparam logic [WIDTH-1:0] ChunkMask = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;       // already inverted for subtract
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;       // carry between chunks
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_k, b_k, s_k;
    logic [CHUNK:0]   slice;
    logic             cout_k;
    logic             cin_msb;

    // Ripple slice for the chunk selected by the counter
    always_comb begin
        base    = 32'(cnt_q) * CHUNK;
        a_k     = CHUNK'(a_q >> base);
        b_k     = CHUNK'(b_q >> base);
        slice   = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, c_q};
        s_k     = slice[CHUNK-1:0];
        cout_k  = slice[CHUNK];
        // Carry into the top bit of this chunk; only meaningful on the last chunk
        cin_msb = a_k[CHUNK-1] ^ b_k[CHUNK-1] ^ s_k[CHUNK-1];
    end

    // Next-state: operand capture, chunk accumulation, result hand-off
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    a_d     = a_i;
                    b_d     = sub_i ? ~b_i : b_i;
                    c_d     = sub_i | carry_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d = (sum_q & ~(ChunkMask << base)) | (WIDTH'(s_k) << base);
                c_d   = cout_k;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    carry_d = cout_k;
                    ovf_d   = cin_msb ^ cout_k;
                    zero_d  = (sum_d == '0);
                end
            end
            StDone: begin
                if (ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign ready_o    = (state_q == StIdle);
    assign valid_o    = (state_q == StDone);
    assign sum_o      = sum_q;
    assign carry_o    = carry_q;
    assign overflow_o = ovf_q;
    assign zero_o     = zero_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: three instances (CHUNK = 4, 1, 16) checked every
// cycle against an integer-arithmetic reference, plus directed literal cases.
module tb_chunked_adder;

    localparam int NI = 3;

    typedef struct packed {
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i[NI], valid_i[NI], ready_o[NI], carry_i[NI], sub_i[NI];
    logic        valid_o[NI], ready_i[NI], carry_o[NI], overflow_o[NI], zero_o[NI];
    logic [15:0] a_i[NI], b_i[NI], sum_o[NI];

    int n_chk  = 0;
    int n_fail = 0;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        chunked_adder #(
            .WIDTH(16),
            .CHUNK(gi == 0 ? 4 : (gi == 1 ? 1 : 16))
        ) u_dut (
            .clk_i     (clk),
            .rst_i     (rst_i[gi]),
            .valid_i   (valid_i[gi]),
            .ready_o   (ready_o[gi]),
            .a_i       (a_i[gi]),
            .b_i       (b_i[gi]),
            .carry_i   (carry_i[gi]),
            .sub_i     (sub_i[gi]),
            .valid_o   (valid_o[gi]),
            .ready_i   (ready_i[gi]),
            .sum_o     (sum_o[gi]),
            .carry_o   (carry_o[gi]),
            .overflow_o(overflow_o[gi]),
            .zero_o    (zero_o[gi])
        );
    end

    function automatic int nch(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 16 : 1);
    endfunction

    // Reference: plain unsigned/signed integer arithmetic
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        res_t r;
        int   ua, ub, us, sa, sb, ss;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            us      = ua - ub;
            ss      = sa - sb;
            r.carry = (ua >= ub);
        end else begin
            us      = ua + ub + int'(cin);
            ss      = sa + sb + int'(cin);
            r.carry = (us > 65535);
        end
        r.sum  = us[15:0];
        r.ovf  = (ss > 32767) || (ss < -32768);
        r.zero = (r.sum == 16'h0000);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // Per-instance model state
    logic pending[NI]   = '{default: 1'b0};
    int   lat[NI]       = '{default: 0};
    res_t exp_r[NI];
    logic rst_seen[NI]  = '{default: 1'b0};
    logic started[NI]   = '{default: 1'b0};
    logic exp_v;

    // Compare every cycle, then advance the model for the coming edge
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (started[i]) begin
                exp_v = pending[i] && (lat[i] >= nch(i));
                chk($sformatf("ready_o[%0d]", i), 32'(ready_o[i]), 32'(!pending[i]));
                chk($sformatf("valid_o[%0d]", i), 32'(valid_o[i]), 32'(exp_v));
                if (exp_v) begin
                    chk($sformatf("result[%0d]", i),
                        32'({sum_o[i], carry_o[i], overflow_o[i], zero_o[i]}), 32'(exp_r[i]));
                end
                if (rst_seen[i]) begin
                    chk($sformatf("reset_outs[%0d]", i),
                        32'({sum_o[i], carry_o[i], overflow_o[i], zero_o[i]}), 32'(0));
                end
            end
            if (rst_i[i]) begin
                pending[i]  = 1'b0;
                rst_seen[i] = 1'b1;
                started[i]  = 1'b1;
            end else begin
                rst_seen[i] = 1'b0;
                if (pending[i]) begin
                    if (lat[i] >= nch(i)) begin
                        if (ready_i[i]) pending[i] = 1'b0;
                    end else begin
                        lat[i]++;
                    end
                end else if (valid_i[i]) begin
                    pending[i] = 1'b1;
                    lat[i]     = 0;
                    exp_r[i]   = model(a_i[i], b_i[i], carry_i[i], sub_i[i]);
                end
            end
        end
    end

    // Issue one operation on an idle instance; called at posedge+#1
    task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input int hold,
                         output res_t r, output int n);
        a_i[i] = a; b_i[i] = b; carry_i[i] = cin; sub_i[i] = sub; valid_i[i] = 1'b1;
        @(posedge clk); #1;
        valid_i[i] = 1'b0;
        a_i[i] = 16'($urandom); b_i[i] = 16'($urandom);
        carry_i[i] = 1'($urandom); sub_i[i] = 1'($urandom);
        n = 0;
        while (!valid_o[i] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!valid_o[i]) chk($sformatf("timeout[%0d]", i), 32'(valid_o[i]), 32'(1));
        r = {sum_o[i], carry_o[i], overflow_o[i], zero_o[i]};
        repeat (hold) begin
            @(posedge clk); #1;
        end
        ready_i[i] = 1'b1;
        @(posedge clk); #1;
        ready_i[i] = 1'b0;
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] corners[4];
        corners = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return 16'($urandom);
    endfunction

    initial begin
        res_t r, r1;
        int   n;

        for (int i = 0; i < NI; i++) begin
            rst_i[i] = 1'b1; valid_i[i] = 1'b0; ready_i[i] = 1'b0;
            a_i[i] = '0; b_i[i] = '0; carry_i[i] = 1'b0; sub_i[i] = 1'b0;
        end

        // Pin the reference to hand-computed values
        chk("model_add_00ff", 32'(model(16'h00FF, 16'h0001, 1'b0, 1'b0)), 32'({16'h0100, 3'b000}));
        chk("model_add_ffff", 32'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'({16'h0000, 3'b101}));
        chk("model_add_cin",  32'(model(16'h7FFF, 16'h0000, 1'b1, 1'b0)), 32'({16'h8000, 3'b010}));
        chk("model_sub_5_7",  32'(model(16'h0005, 16'h0007, 1'b1, 1'b1)), 32'({16'hFFFE, 3'b000}));
        chk("model_sub_8000", 32'(model(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'({16'h7FFF, 3'b110}));

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rst_i[i] = 1'b0;
        chk("reset_ready", 32'(ready_o[0]), 32'(1));
        chk("reset_valid", 32'(valid_o[0]), 32'(0));

        // Directed literal cases on the default configuration
        do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, r, n);
        chk("add_00ff", 32'(r), 32'({16'h0100, 3'b000}));
        chk("latency_c4", n, 4);
        do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, r, n);
        chk("add_ffff", 32'(r), 32'({16'h0000, 3'b101}));
        do_op(0, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 0, r, n);
        chk("add_cin", 32'(r), 32'({16'h8000, 3'b010}));
        do_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 0, r, n);
        chk("sub_5_7", 32'(r), 32'({16'hFFFE, 3'b000}));
        do_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 2, r, n);
        chk("sub_8000", 32'(r), 32'({16'h7FFF, 3'b110}));

        // Backpressure: valid_i stays high with new operands while result is held
        a_i[0] = 16'h1000; b_i[0] = 16'h0234; carry_i[0] = 1'b0; sub_i[0] = 1'b0;
        valid_i[0] = 1'b1;
        @(posedge clk); #1;
        a_i[0] = 16'h4444; b_i[0] = 16'h1111;
        n = 0;
        while (!valid_o[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        r1 = {sum_o[0], carry_o[0], overflow_o[0], zero_o[0]};
        chk("bp_first", 32'(r1), 32'({16'h1234, 3'b000}));
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_hold", 32'({sum_o[0], carry_o[0], overflow_o[0], zero_o[0]}), 32'(r1));
            chk("bp_ready_low", 32'(ready_o[0]), 32'(0));
        end
        ready_i[0] = 1'b1;
        @(posedge clk); #1;
        ready_i[0] = 1'b0;
        chk("bp_idle_ready", 32'(ready_o[0]), 32'(1));
        @(posedge clk); #1;
        valid_i[0] = 1'b0;
        n = 0;
        while (!valid_o[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_second", 32'(sum_o[0]), 32'(16'h5555));
        ready_i[0] = 1'b1;
        @(posedge clk); #1;
        ready_i[0] = 1'b0;

        // Reset two cycles into RUN aborts the operation
        a_i[0] = 16'hABCD; b_i[0] = 16'h1111; valid_i[0] = 1'b1;
        @(posedge clk); #1;
        valid_i[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_i[0] = 1'b1;
        @(posedge clk); #1;
        rst_i[0] = 1'b0;
        chk("abort_valid", 32'(valid_o[0]), 32'(0));
        chk("abort_ready", 32'(ready_o[0]), 32'(1));
        chk("abort_sum", 32'(sum_o[0]), 32'(0));
        repeat (6) begin
            @(posedge clk); #1;
        end
        do_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 0, r, n);
        chk("after_abort", 32'(r.sum), 32'(16'h2345));

        // Alternate chunk sizes
        do_op(1, 16'h1234, 16'h1111, 1'b0, 1'b0, 0, r, n);
        chk("c1_sum", 32'(r.sum), 32'(16'h2345));
        chk("latency_c1", n, 16);
        do_op(2, 16'h1234, 16'h1111, 1'b0, 1'b0, 0, r, n);
        chk("c16_sum", 32'(r.sum), 32'(16'h2345));
        chk("latency_c16", n, 1);

        // Random operands and modes, checked by the per-cycle compare process
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 1000; k++) begin
                do_op(i, pick(), pick(), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), r, n);
            end
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
